mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the multicycle CPU's memory bus: serves the fetch/load/store
//  requests issued by the control unit (address via Iord mux, MemWr) from an internal
//  word array with programmable wait states. Produces read data and a completion pulse so
//  the control unit can replace fixed WaitMemRead cycles with a ready handshake.
// PARAMETERS
//  DEPTH_WORDS  256  number of 32-bit words stored; byte address range 0..4*DEPTH_WORDS-1
//  READ_LAT     2    cycles from read acceptance to MemReady (legal 1..7)
//  WRITE_LAT    1    cycles from write acceptance to commit/MemReady (legal 1..7)
// PORTS
//  clock      in   1   rising-edge clock
//  reset      in   1   asynchronous, active-low (0 = reset)
//  Address    in   32  byte address, sampled at acceptance
//  MemRd      in   1   read request
//  MemWr      in   1   write request
//  WriteData  in   32  store data, sampled at acceptance
//  ByteEn     in   4   byte lane enables for writes (bit i -> WriteData[8i+7:8i])
//  MemData    out  32  read data, registered; valid when MemReady=1, held until next read
//  MemReady   out  1   one-cycle pulse: transaction complete
//  Busy       out  1   1 while a transaction is outstanding
//  Fault      out  1   pulses with MemReady when transaction was rejected
// BEHAVIOUR
//  - Reset (async, reset=0): FSM->IDLE, counter=0, MemData=0, MemReady=0, Busy=0, Fault=0.
//    Array contents are NOT cleared. Reset mid-transaction aborts it; no write is committed.
//  - FSM states: IDLE, RD_WAIT, WR_WAIT, DONE.
//  - IDLE: request accepted at edge k when Busy=0 and (MemRd|MemWr)=1. Address, WriteData,
//    ByteEn latched; counter loaded with LAT-1; Busy=1 from edge k. -> RD_WAIT or WR_WAIT.
//    LAT=1 goes straight to DONE.
//  - RD_WAIT/WR_WAIT: counter decrements each cycle; at 0 -> DONE.
//  - DONE (one cycle, entered at edge k+LAT): MemReady=1, Busy=1; read: MemData updated at
//    edge k+LAT with array[Address[31:2]]; write: enabled bytes committed at edge k+LAT.
//    Next edge -> IDLE, MemReady=0, Busy=0. New request accepted earliest at edge k+LAT+1.
//  - Requests while Busy=1 are ignored (not queued, no effect).
//  - MemRd and MemWr both 1 at acceptance: rejected, READ_LAT timing, Fault=1 with MemReady.
//  - Address[1:0]!=0 or Address[31:2]>=DEPTH_WORDS: rejected with Fault=1 at MemReady after
//    the normal latency; write suppressed; read sets MemData=0.
//  - ByteEn=0 write: completes normally, no array change, Fault=0.
//  - Writes never alter MemData. Read after write to same word returns committed value.
//  - Word index = Address[31:2]; counter 3 bits; no arithmetic on data.
// TESTING
//  - Reset: drive reset=0 mid RD_WAIT -> all outputs 0 immediately, no MemReady afterwards.
//  - Write 0xDEADBEEF to 0x10 ByteEn=4'hF, then read 0x10 -> MemReady 2 cycles after read
//    acceptance, MemData=0xDEADBEEF, Fault=0.
//  - Write 0x000000AA to 0x10 ByteEn=4'b0001, read 0x10 -> MemData=0xDEADBEAA.
//  - Read 0x13 (misaligned) and 0x400 (DEPTH_WORDS=256) -> Fault=1, MemData=0, array unchanged.
//  - Issue read at 0x20 and pulse MemWr during Busy -> second request ignored, one MemReady.
//  - Sweep READ_LAT=1 and 7 -> MemReady exactly 1 / 7 cycles after acceptance.

Source files
------------

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-array memory responder with programmable wait states and ready/fault handshake
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int READ_LAT    = 2,
    parameter int WRITE_LAT   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [31:0] WriteData,
    input  logic [3:0]  ByteEn,
    output logic [31:0] MemData,
    output logic        MemReady,
    output logic        Busy,
    output logic        Fault
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

    state_t        state;
    logic [2:0]    count;
    logic [AW-1:0] word_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic          reject_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic req_reject;
    logic commit;

    // Simultaneous read+write, misalignment and out-of-range words all reject the transaction.
    assign req_reject = (MemRd & MemWr) | (Address[1:0] != 2'b00)
                      | (Address[31:2] >= 30'(DEPTH_WORDS));
    assign commit     = (state == WR_WAIT) && (count == 3'd0) && !reject_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= 3'd0;
            word_q   <= '0;
            wdata_q  <= 32'd0;
            be_q     <= 4'd0;
            reject_q <= 1'b0;
            MemData  <= 32'd0;
            MemReady <= 1'b0;
            Busy     <= 1'b0;
            Fault    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    MemReady <= 1'b0;
                    Fault    <= 1'b0;
                    if (MemRd | MemWr) begin
                        word_q   <= Address[AW+1:2];
                        wdata_q  <= WriteData;
                        be_q     <= ByteEn;
                        reject_q <= req_reject;
                        Busy     <= 1'b1;
                        if (MemRd) begin
                            count <= 3'(READ_LAT - 1);
                            state <= RD_WAIT;
                        end else begin
                            count <= 3'(WRITE_LAT - 1);
                            state <= WR_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (count == 3'd0) begin
                        state    <= DONE;
                        MemReady <= 1'b1;
                        Fault    <= reject_q;
                        MemData  <= reject_q ? 32'd0 : mem[word_q];
                    end else begin
                        count <= count - 3'd1;
                    end
                end
                WR_WAIT: begin
                    if (count == 3'd0) begin
                        state    <= DONE;
                        MemReady <= 1'b1;
                        Fault    <= reject_q;
                    end else begin
                        count <= count - 3'd1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    MemReady <= 1'b0;
                    Fault    <= 1'b0;
                    Busy     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clock) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) mem[word_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder across three latency configurations
module tb_mem_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Address = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic        MemRd = 1'b0;
    logic        MemWr = 1'b0;
    logic [3:0]  ByteEn = 4'd0;

    logic [31:0] md  [3];
    logic        rdy [3];
    logic        bsy [3];
    logic        flt [3];

    localparam int RLAT [3] = '{2, 1, 7};
    localparam int WLAT [3] = '{1, 1, 3};

    always #5 clock = ~clock;

    mem_responder #(.DEPTH_WORDS(256), .READ_LAT(2), .WRITE_LAT(1)) u0 (
        .clock(clock), .reset(reset), .Address(Address), .MemRd(MemRd), .MemWr(MemWr),
        .WriteData(WriteData), .ByteEn(ByteEn), .MemData(md[0]), .MemReady(rdy[0]),
        .Busy(bsy[0]), .Fault(flt[0]));
    mem_responder #(.DEPTH_WORDS(256), .READ_LAT(1), .WRITE_LAT(1)) u1 (
        .clock(clock), .reset(reset), .Address(Address), .MemRd(MemRd), .MemWr(MemWr),
        .WriteData(WriteData), .ByteEn(ByteEn), .MemData(md[1]), .MemReady(rdy[1]),
        .Busy(bsy[1]), .Fault(flt[1]));
    mem_responder #(.DEPTH_WORDS(256), .READ_LAT(7), .WRITE_LAT(3)) u2 (
        .clock(clock), .reset(reset), .Address(Address), .MemRd(MemRd), .MemWr(MemWr),
        .WriteData(WriteData), .ByteEn(ByteEn), .MemData(md[2]), .MemReady(rdy[2]),
        .Busy(bsy[2]), .Fault(flt[2]));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: each transaction completes LAT edges after acceptance.
    bit          m_busy [3], m_ready [3], m_fault [3], m_dknown [3];
    logic [31:0] m_data [3];
    int          m_done [3];
    bit          t_rd [3], t_fault [3];
    logic [7:0]  t_w [3];
    logic [31:0] t_wd [3];
    logic [3:0]  t_be [3];
    logic [31:0] mm [3][256];
    logic [3:0]  mk [3][256];
    int          edge_no = 0;
    bit          cmp_en = 0;

    always @(posedge clock or negedge reset) begin
        edge_no++;
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                m_busy[i] = 0; m_ready[i] = 0; m_fault[i] = 0;
                m_data[i] = 32'd0; m_dknown[i] = 1;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                bit prev;
                prev = m_busy[i];
                m_ready[i] = 0;
                m_fault[i] = 0;
                if (prev && edge_no == m_done[i]) begin
                    m_ready[i] = 1;
                    m_fault[i] = t_fault[i];
                    if (t_rd[i]) begin
                        m_data[i]   = t_fault[i] ? 32'd0 : mm[i][t_w[i]];
                        m_dknown[i] = t_fault[i] || (mk[i][t_w[i]] == 4'hF);
                    end else if (!t_fault[i]) begin
                        for (int b = 0; b < 4; b++) if (t_be[i][b]) begin
                            mm[i][t_w[i]][8*b +: 8] = t_wd[i][8*b +: 8];
                            mk[i][t_w[i]][b] = 1'b1;
                        end
                    end
                end
                if (prev && edge_no == m_done[i] + 1) m_busy[i] = 0;
                if (!prev && (MemRd || MemWr)) begin
                    m_busy[i]  = 1;
                    t_rd[i]    = MemRd;
                    t_fault[i] = (MemRd && MemWr) || (Address[1:0] != 2'b00) || (Address >= 32'd1024);
                    m_done[i]  = edge_no + (MemRd ? RLAT[i] : WLAT[i]);
                    t_w[i]     = Address[9:2];
                    t_wd[i]    = WriteData;
                    t_be[i]    = ByteEn;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d MemReady @%0d", i, edge_no), 32'(rdy[i]), 32'(m_ready[i]));
                chk($sformatf("u%0d Busy @%0d", i, edge_no), 32'(bsy[i]), 32'(m_busy[i]));
                chk($sformatf("u%0d Fault @%0d", i, edge_no), 32'(flt[i]), 32'(m_fault[i]));
                if (m_dknown[i]) chk($sformatf("u%0d MemData @%0d", i, edge_no), md[i], m_data[i]);
            end
        end
    end

    int          lat [3];
    int          pulses [3];
    logic [31:0] rdat [3];
    logic        rflt [3];

    task automatic op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input bit intrude);
        @(posedge clock); #1;
        MemRd = rd; MemWr = wr; Address = a; WriteData = d; ByteEn = be;
        @(posedge clock); #1;
        MemRd = 0; MemWr = 0;
        if (intrude) begin
            MemWr = 1; Address = 32'h20; WriteData = 32'hFFFF_FFFF; ByteEn = 4'hF;
        end
        for (int i = 0; i < 3; i++) begin
            lat[i] = -1; pulses[i] = 0; rdat[i] = 32'hX; rflt[i] = 1'bX;
        end
        for (int n = 1; n <= 12; n++) begin
            @(posedge clock);
            if (intrude && n == 1) begin #1; MemWr = 0; end
            @(negedge clock);
            for (int i = 0; i < 3; i++) if (rdy[i]) begin
                pulses[i]++;
                if (lat[i] < 0) begin lat[i] = n; rdat[i] = md[i]; rflt[i] = flt[i]; end
            end
        end
    endtask

    task automatic expect_all(input string name, input bit is_rd, input logic [31:0] d, input logic f);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s u%0d latency", name, i), lat[i], is_rd ? RLAT[i] : WLAT[i]);
            chk($sformatf("%s u%0d pulses", name, i), pulses[i], 32'd1);
            chk($sformatf("%s u%0d fault", name, i), 32'(rflt[i]), 32'(f));
            if (is_rd) chk($sformatf("%s u%0d data", name, i), rdat[i], d);
        end
    endtask

    task automatic reset_mid(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        @(posedge clock); #1;
        MemRd = rd; MemWr = wr; Address = a; WriteData = d; ByteEn = 4'hF;
        @(posedge clock); #1;
        MemRd = 0; MemWr = 0;
        @(posedge clock); #2;
        reset = 0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("async reset u%0d outs", i), {md[i], rdy[i], bsy[i], flt[i]}, 32'd0);
        end
        @(negedge clock);
        reset = 1;
        for (int i = 0; i < 3; i++) pulses[i] = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            for (int i = 0; i < 3; i++) if (rdy[i]) pulses[i]++;
        end
        for (int i = 0; i < 3; i++) chk($sformatf("post-reset u%0d pulses", i), pulses[i], 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) for (int w = 0; w < 256; w++) mk[i][w] = 4'h0;
        repeat (2) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset u%0d MemData", i), md[i], 32'd0);
            chk($sformatf("reset u%0d flags", i), {29'd0, rdy[i], bsy[i], flt[i]}, 32'd0);
        end
        reset = 1;
        cmp_en = 1;

        op(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);  expect_all("wr full", 0, 32'h0, 1'b0);
        op(1, 0, 32'h10, 32'h0, 4'h0, 0);          expect_all("rd full", 1, 32'hDEAD_BEEF, 1'b0);
        op(0, 1, 32'h10, 32'h0000_00AA, 4'b0001, 0); expect_all("wr byte0", 0, 32'h0, 1'b0);
        op(1, 0, 32'h10, 32'h0, 4'h0, 0);          expect_all("rd merged", 1, 32'hDEAD_BEAA, 1'b0);
        op(1, 0, 32'h13, 32'h0, 4'h0, 0);          expect_all("rd misalign", 1, 32'h0, 1'b1);
        op(1, 0, 32'h400, 32'h0, 4'h0, 0);         expect_all("rd range", 1, 32'h0, 1'b1);
        op(0, 1, 32'h400, 32'h1234_5678, 4'hF, 0); expect_all("wr range", 0, 32'h0, 1'b1);
        op(0, 1, 32'h12, 32'h1234_5678, 4'hF, 0);  expect_all("wr misalign", 0, 32'h0, 1'b1);
        op(0, 1, 32'h10, 32'hFFFF_FFFF, 4'h0, 0);  expect_all("wr be0", 0, 32'h0, 1'b0);
        op(1, 0, 32'h10, 32'h0, 4'h0, 0);          expect_all("rd unchanged", 1, 32'hDEAD_BEAA, 1'b0);
        op(1, 1, 32'h10, 32'h0, 4'hF, 0);          expect_all("rd+wr", 1, 32'h0, 1'b1);
        op(0, 1, 32'h20, 32'h1122_3344, 4'hF, 0);  expect_all("wr 0x20", 0, 32'h0, 1'b0);
        op(1, 0, 32'h20, 32'h0, 4'h0, 1);          expect_all("rd intrude", 1, 32'h1122_3344, 1'b0);
        op(1, 0, 32'h20, 32'h0, 4'h0, 0);          expect_all("rd after intrude", 1, 32'h1122_3344, 1'b0);

        reset_mid(1, 0, 32'h10, 32'h0);
        op(1, 0, 32'h10, 32'h0, 4'h0, 0);          expect_all("rd after reset", 1, 32'hDEAD_BEAA, 1'b0);

        reset_mid(0, 1, 32'h10, 32'h0BAD_F00D);
        op(1, 0, 32'h10, 32'h0, 4'h0, 0);
        chk("wr abort u0 data", rdat[0], 32'h0BAD_F00D);
        chk("wr abort u1 data", rdat[1], 32'h0BAD_F00D);
        chk("wr abort u2 data", rdat[2], 32'hDEAD_BEAA);

        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
